// File: rtl/qspi_target_responder_if.sv
// Purpose: QSPI target pins plus the byte-wide backing-memory port, bundled for one connection.
// Latency: none, wiring only.
// Backpressure: none; memory reads are request/valid pulses, writes are fire-and-forget strobes.
interface qspi_target_responder_if #(
    parameter int ADDR_W = 24
);
    logic              sclk;
    logic              cs_n;
    logic [3:0]        io_in;
    logic [3:0]        io_out;
    logic [3:0]        io_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_req;
    logic              mem_rd_valid;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;
    logic              busy;
    logic              underrun;

    // responder side
    modport slave (
        input  sclk, cs_n, io_in, mem_rd_valid, mem_rd_data,
        output io_out, io_oe, mem_addr, mem_rd_req, mem_wr_en, mem_wr_data, busy, underrun
    );

    // bus controller plus memory model side
    modport master (
        output sclk, cs_n, io_in, mem_rd_valid, mem_rd_data,
        input  io_out, io_oe, mem_addr, mem_rd_req, mem_wr_en, mem_wr_data, busy, underrun
    );
endinterface

// File: rtl/qspi_target_responder.sv
// Purpose: QSPI flash-style target; decodes cmd + 24-bit address, serves reads/writes from byte memory.
// Latency: pins are synchronised in 2 clk; io_out/io_oe change 3 clk after the SCLK falling pin edge.
// Backpressure: none; a read byte not back in time is sent as 0xFF and flags sticky underrun.
module qspi_target_responder #(
    parameter int ADDR_W     = 24,
    parameter int DUMMY_QUAD = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    qspi_target_responder_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE} state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_QREAD = 8'h6B;
    localparam logic [7:0] CMD_PP    = 8'h02;
    localparam logic [7:0] CMD_QPP   = 8'h32;
    localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_QUAD - 1);

    state_t            state_q, state_d;
    logic              sclk_meta, sclk_sync, sclk_prev;
    logic              cs_meta, cs_sync, cs_prev;
    logic [3:0]        io_meta, io_sync;
    logic [22:0]       sh;
    logic [7:0]        cmd;
    logic [4:0]        bit_cnt;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        rd_buf, tx_sh, wr_sh, wr_dat_q;
    logic              buf_full, rd_req_q, wr_en_q, underrun_q;
    logic [2:0]        rd_out, tx_cnt, wr_cnt;
    logic [3:0]        io_out_q, io_oe_q;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic is_read, is_quad_rd, is_quad_wr, addr_done, byte_start, rd_issue, rd_take;
    logic [7:0]  cmd_next, next_byte;
    logic [23:0] addr_next;

    assign sclk_rise  = sclk_sync & ~sclk_prev;
    assign sclk_fall  = ~sclk_sync & sclk_prev;
    assign cs_fall    = ~cs_sync & cs_prev;
    assign cs_rise    = cs_sync & ~cs_prev;
    assign cmd_next   = {sh[6:0], io_sync[0]};
    assign addr_next  = {sh, io_sync[0]};
    assign is_quad_rd = (cmd == CMD_QREAD);
    assign is_quad_wr = (cmd == CMD_QPP);
    assign is_read    = (cmd == CMD_READ) || is_quad_rd;
    assign addr_done  = (state_q == ADDR) && sclk_rise && (bit_cnt == 5'd23) && !cs_rise;
    assign byte_start = (state_q == RD_DATA) && sclk_fall && (tx_cnt == 3'd0) && !cs_rise;
    assign rd_issue   = (addr_done && is_read) || byte_start;
    // a response only counts while a request of ours is still in flight
    assign rd_take    = bus.mem_rd_valid && (rd_out != 3'd0);
    assign next_byte  = buf_full ? rd_buf : 8'hFF;

    assign bus.io_out      = io_out_q;
    assign bus.io_oe       = io_oe_q;
    assign bus.mem_addr    = addr;
    assign bus.mem_rd_req  = rd_req_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_data = wr_dat_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.underrun    = underrun_q;

    // two-flop synchronisers plus previous-value registers for edge detection; CS_n idles high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {sclk_meta, sclk_sync, sclk_prev} <= 3'b000;
            {cs_meta, cs_sync, cs_prev}       <= 3'b111;
            io_meta <= 4'h0;
            io_sync <= 4'h0;
        end else begin
            sclk_meta <= bus.sclk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            cs_meta   <= bus.cs_n;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            io_meta   <= bus.io_in;
            io_sync   <= io_meta;
        end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state decode; CS_n deassertion overrides everything
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (cs_fall) state_d = CMD;
                CMD:   if (sclk_rise && bit_cnt == 5'd7) begin
                           if (cmd_next == CMD_READ || cmd_next == CMD_QREAD ||
                               cmd_next == CMD_PP || cmd_next == CMD_QPP)
                               state_d = ADDR;
                           else
                               state_d = IGNORE;
                       end
                ADDR:  if (addr_done) begin
                           if (is_quad_rd)           state_d = DUMMY;
                           else if (cmd == CMD_READ) state_d = RD_DATA;
                           else                      state_d = WR_DATA;
                       end
                DUMMY: if (sclk_rise && bit_cnt == DUMMY_LAST) state_d = RD_DATA;
                default: state_d = state_q;
            endcase
        end
    end

    // datapath: shifting, read buffer, transmit shifter, write assembly, memory strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh <= '0; cmd <= '0; bit_cnt <= '0; addr <= '0;
            rd_buf <= '0; buf_full <= 1'b0; rd_out <= '0;
            tx_sh <= '0; tx_cnt <= '0; wr_sh <= '0; wr_cnt <= '0;
            io_out_q <= '0; io_oe_q <= '0;
            rd_req_q <= 1'b0; wr_en_q <= 1'b0; wr_dat_q <= '0; underrun_q <= 1'b0;
        end else begin
            rd_req_q <= 1'b0;
            wr_en_q  <= 1'b0;
            if (cs_rise) begin
                // frame over: release the pads, drop partial bytes and pending responses
                io_oe_q <= '0; io_out_q <= '0; rd_out <= '0; buf_full <= 1'b0;
                tx_cnt <= '0; wr_cnt <= '0; bit_cnt <= '0;
            end else begin
                case (state_q)
                    IDLE: if (cs_fall) begin
                        bit_cnt <= '0; underrun_q <= 1'b0; tx_cnt <= '0; wr_cnt <= '0;
                    end
                    CMD: if (sclk_rise) begin
                        sh <= addr_next[22:0];
                        if (bit_cnt == 5'd7) begin
                            cmd <= cmd_next;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    ADDR: if (sclk_rise) begin
                        sh <= addr_next[22:0];
                        if (bit_cnt == 5'd23) begin
                            addr <= addr_next[ADDR_W-1:0];
                            bit_cnt <= '0;
                            rd_req_q <= is_read;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    DUMMY: if (sclk_rise) bit_cnt <= bit_cnt + 5'd1;
                    RD_DATA: if (sclk_fall) begin
                        io_oe_q <= is_quad_rd ? 4'b1111 : 4'b0010;
                        if (tx_cnt == 3'd0) begin
                            // new byte: take the buffer (or 0xFF filler) and prefetch the next one
                            buf_full <= 1'b0;
                            addr     <= addr + ADDR_W'(1);
                            rd_req_q <= 1'b1;
                            if (!buf_full) underrun_q <= 1'b1;
                            if (is_quad_rd) begin
                                io_out_q <= next_byte[7:4];
                                tx_sh    <= {next_byte[3:0], 4'h0};
                                tx_cnt   <= 3'd1;
                            end else begin
                                io_out_q <= {2'b00, next_byte[7], 1'b0};
                                tx_sh    <= {next_byte[6:0], 1'b0};
                                tx_cnt   <= 3'd7;
                            end
                        end else begin
                            tx_cnt <= tx_cnt - 3'd1;
                            if (is_quad_rd) begin
                                io_out_q <= tx_sh[7:4];
                                tx_sh    <= {tx_sh[3:0], 4'h0};
                            end else begin
                                io_out_q <= {2'b00, tx_sh[7], 1'b0};
                                tx_sh    <= {tx_sh[6:0], 1'b0};
                            end
                        end
                    end
                    WR_DATA: begin
                        // address advances the clk after the strobe so the strobe sees the old one
                        if (wr_en_q) addr <= addr + ADDR_W'(1);
                        if (sclk_rise) begin
                            if (is_quad_wr) begin
                                wr_sh <= {wr_sh[3:0], io_sync};
                                if (wr_cnt == 3'd1) begin
                                    wr_en_q  <= 1'b1;
                                    wr_dat_q <= {wr_sh[3:0], io_sync};
                                    wr_cnt   <= '0;
                                end else begin
                                    wr_cnt <= wr_cnt + 3'd1;
                                end
                            end else begin
                                wr_sh <= {wr_sh[6:0], io_sync[0]};
                                if (wr_cnt == 3'd7) begin
                                    wr_en_q  <= 1'b1;
                                    wr_dat_q <= {wr_sh[6:0], io_sync[0]};
                                    wr_cnt   <= '0;
                                end else begin
                                    wr_cnt <= wr_cnt + 3'd1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
                // a response landing on a byte start counts as late and serves the following byte
                if (rd_take) begin
                    rd_buf   <= bus.mem_rd_data;
                    buf_full <= 1'b1;
                end
                rd_out <= rd_out + 3'(rd_issue) - 3'(rd_take);
            end
        end
    end
endmodule

// File: tb/tb_qspi_target_responder.sv
// Purpose: directed bench acting as QSPI controller and backing memory, with scoreboard queues.
// Latency: SCLK half period is H clk; memory answers mem_lat clk after it sees a request.
// Backpressure: none; all waits on the DUT are bounded.
module tb_qspi_target_responder;
    localparam int H = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    qspi_target_responder_if #(.ADDR_W(24)) bus ();
    qspi_target_responder #(.ADDR_W(24), .DUMMY_QUAD(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mem_lat = 2;
    int wr_seen = 0;
    int rd_req_seen = 0;
    logic [7:0]  mem_arr [int unsigned];
    logic [31:0] exp_wr [$];
    logic [3:0]  exp_rd [$];
    int unsigned pend_addr [$];
    int          pend_due [$];
    logic [3:0]  last_o, last_oe, oe_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_read(input int unsigned a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return 8'h00;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // memory model: fixed-latency responder, one response per clk, in request order
    initial begin
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = 8'h00;
        forever begin
            @(posedge clk); #1;
            bus.mem_rd_valid = 1'b0;
            if (reset) begin
                pend_addr.delete();
                pend_due.delete();
            end else begin
                if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                    bus.mem_rd_valid = 1'b1;
                    bus.mem_rd_data  = mem_read(pend_addr[0]);
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end
                if (bus.mem_rd_req) begin
                    pend_addr.push_back(32'(bus.mem_addr));
                    pend_due.push_back(cyc + mem_lat);
                    rd_req_seen++;
                end
            end
        end
    end

    // write monitor: every strobe pops the write scoreboard
    always @(negedge clk) begin : wr_mon
        logic [31:0] e;
        if (!reset && bus.mem_wr_en) begin
            wr_seen++;
            if (exp_wr.size() > 0) begin
                e = exp_wr.pop_front();
                check("wr_addr_data", {bus.mem_addr, bus.mem_wr_data}, e);
            end
        end
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sclk_cycle(input logic [3:0] d);
        bus.io_in = d;
        clk_wait(H);
        last_o  = bus.io_out;
        last_oe = bus.io_oe;
        oe_acc  = oe_acc | bus.io_oe;
        bus.sclk = 1'b1;
        clk_wait(H);
        bus.sclk = 1'b0;
    endtask

    task automatic send_single(input logic [31:0] v, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) sclk_cycle({3'b000, v[i]});
    endtask

    task automatic cs_begin();
        bus.cs_n = 1'b0;
        clk_wait(4);
    endtask

    task automatic cs_end();
        clk_wait(H);
        bus.cs_n = 1'b1;
        clk_wait(6);
    endtask

    task automatic push_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_rd.push_back({2'b00, b[i], 1'b0});
    endtask

    task automatic read_phase(input int n, input logic [3:0] exp_oe);
        logic [3:0] e;
        for (int i = 0; i < n; i++) begin
            e = (exp_rd.size() > 0) ? exp_rd.pop_front() : 4'hx;
            sclk_cycle(4'h0);
            check("rd_io_out", 32'(last_o), 32'(e));
            check("rd_io_oe", 32'(last_oe), 32'(exp_oe));
        end
    endtask

    initial begin
        int w0, r0;
        bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.io_in = 4'h0; reset = 1'b1; oe_acc = 4'h0;
        mem_arr[32'h10] = 8'hA5; mem_arr[32'h11] = 8'h3C;
        mem_arr[32'hFF] = 8'h12; mem_arr[32'h100] = 8'h34;
        mem_arr[32'h20] = 8'h77; mem_arr[32'h30] = 8'hC3;
        clk_wait(3);
        check("rst_io_oe", 32'(bus.io_oe), 0);
        check("rst_io_out", 32'(bus.io_out), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_underrun", 32'(bus.underrun), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_strobes", 32'({bus.mem_rd_req, bus.mem_wr_en}), 0);
        reset = 1'b0;
        clk_wait(4);

        // single-line read 0x03 @0x10
        mem_lat = 2; oe_acc = 4'h0;
        push_bits(8'hA5); push_bits(8'h3C);
        cs_begin();
        send_single(32'h03, 8);
        send_single(32'h000010, 24);
        check("t1_oe_cmd_addr", 32'(oe_acc | bus.io_oe), 0);
        read_phase(16, 4'b0010);
        check("t1_underrun", 32'(bus.underrun), 0);
        cs_end();
        check("t1_oe_after", 32'(bus.io_oe), 0);
        check("t1_busy_after", 32'(bus.busy), 0);

        // quad-output read 0x6B @0xFF with 8 dummy cycles
        oe_acc = 4'h0;
        exp_rd.push_back(4'h1); exp_rd.push_back(4'h2); exp_rd.push_back(4'h3); exp_rd.push_back(4'h4);
        cs_begin();
        send_single(32'h6B, 8);
        send_single(32'h0000FF, 24);
        for (int i = 0; i < 8; i++) sclk_cycle(4'h0);
        check("t2_oe_dummy", 32'(oe_acc), 0);
        read_phase(4, 4'b1111);
        cs_end();

        // quad program 0x32 @0xFFFFFF, wraps to 0
        w0 = wr_seen; oe_acc = 4'h0;
        exp_wr.push_back({24'hFFFFFF, 8'hDE});
        exp_wr.push_back({24'h000000, 8'hAD});
        cs_begin();
        send_single(32'h32, 8);
        send_single(32'hFFFFFF, 24);
        sclk_cycle(4'hD); sclk_cycle(4'hE); sclk_cycle(4'hA); sclk_cycle(4'hD);
        cs_end();
        check("t3_wr_count", 32'(wr_seen - w0), 2);
        check("t3_wr_pending", 32'(exp_wr.size()), 0);
        check("t3_oe", 32'(oe_acc), 0);

        // single program 0x02 @0x40 with 12 bits: one strobe, partial nibble dropped
        w0 = wr_seen;
        exp_wr.push_back({24'h000040, 8'h5A});
        cs_begin();
        send_single(32'h02, 8);
        send_single(32'h000040, 24);
        send_single(32'h5AF, 12);
        cs_end();
        check("t4_wr_count", 32'(wr_seen - w0), 1);
        check("t4_wr_pending", 32'(exp_wr.size()), 0);
        check("t4_busy", 32'(bus.busy), 0);

        // unknown command 0x9F
        w0 = wr_seen; r0 = rd_req_seen; oe_acc = 4'h0;
        cs_begin();
        send_single(32'h9F, 8);
        clk_wait(2);
        check("t5_busy_ignore", 32'(bus.busy), 1);
        for (int i = 0; i < 24; i++) sclk_cycle(4'($urandom_range(0, 15)));
        cs_end();
        check("t5_oe", 32'(oe_acc | bus.io_oe), 0);
        check("t5_wr_count", 32'(wr_seen - w0), 0);
        check("t5_rd_count", 32'(rd_req_seen - r0), 0);
        check("t5_busy_after", 32'(bus.busy), 0);

        // read with slow memory: first byte is 0xFF filler and underrun sticks
        mem_lat = 250;
        push_bits(8'hFF);
        cs_begin();
        send_single(32'h03, 8);
        send_single(32'h000020, 24);
        read_phase(8, 4'b0010);
        check("t6_underrun", 32'(bus.underrun), 1);
        cs_end();
        check("t6_underrun_sticky", 32'(bus.underrun), 1);
        check("t6_busy_after", 32'(bus.busy), 0);
        for (int i = 0; i < 2000 && pend_due.size() > 0; i++) clk_wait(1);
        check("t6_mem_drain", 32'(pend_due.size()), 0);

        // next frame clears underrun; async reset in the middle of read data
        mem_lat = 2;
        cs_begin();
        check("t7_underrun_clr", 32'(bus.underrun), 0);
        check("t7_busy", 32'(bus.busy), 1);
        send_single(32'h03, 8);
        send_single(32'h000030, 24);
        exp_rd.push_back(4'b0010); exp_rd.push_back(4'b0010); exp_rd.push_back(4'b0000);
        read_phase(3, 4'b0010);
        clk_wait(4);
        check("t7_oe_pre_reset", 32'(bus.io_oe), 32'(4'b0010));
        #3 reset = 1'b1;
        #1;
        check("t7_oe_reset", 32'(bus.io_oe), 0);
        check("t7_out_reset", 32'(bus.io_out), 0);
        check("t7_busy_reset", 32'(bus.busy), 0);
        check("t7_addr_reset", 32'(bus.mem_addr), 0);
        bus.cs_n = 1'b1;
        clk_wait(3);
        reset = 1'b0;
        clk_wait(6);
        check("t7_busy_after", 32'(bus.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
